// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM encodings and iteration count.
package div_radix2_pkg;

    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } divState_t;

endpackage

// File: rtl/div_radix2_if.sv
// Execute-stage <-> divider handshake: operands and start/annul in, {rem, quo} and ready out.
interface div_radix2_if #(
    parameter int WIDTH = 32
);

    logic               signed_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    modport master (
        output signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor, restore on borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic        [WIDTH:0] shifted;
    logic signed [WIDTH:0] diff;

    assign shifted = {remIn, quoIn[WIDTH-1]};
    assign diff    = $signed(shifted) - $signed({1'b0, divisor});

    // rem stays below the divisor, so bit WIDTH of the 33-bit difference is an exact borrow flag
    assign remOut = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quoOut = {quoIn[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider producing {remainder, quotient} for HI/LO.
// Optional DIV_ZERO_SHORTCUT_EN: a zero divisor finishes early with a zero result.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    div_radix2_if.slave bus
);

    divState_t              state, nextState;
    logic [DIV_CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]       rem, quo, divisorMag;
    logic [WIDTH-1:0]       stepRem, stepQuo;
    logic                   negRem, negQuo;
    logic [2*WIDTH-1:0]     resultReg, fixed;
    logic                   ready;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic isSigned);
        return (isSigned && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fixUp(input logic signed [WIDTH-1:0] r,
                                                 input logic signed [WIDTH-1:0] q,
                                                 input logic nR,
                                                 input logic nQ);
        logic signed [WIDTH-1:0] rOut, qOut;
        rOut = nR ? -r : r;
        qOut = nQ ? -q : q;
        return {rOut, qOut};
    endfunction

    div_step #(.WIDTH(WIDTH)) uStep (
        .remIn  (rem),
        .quoIn  (quo),
        .divisor(divisorMag),
        .remOut (stepRem),
        .quoOut (stepQuo)
    );

    always_comb begin
        nextState = state;
        if (bus.annul_i) begin
            nextState = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (bus.start_i) begin
`ifdef DIV_ZERO_SHORTCUT_EN
                        nextState = (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
`else
                        nextState = DIV_ON;
`endif
                    end
                end
`ifdef DIV_ZERO_SHORTCUT_EN
                DIV_BYZERO: nextState = bus.start_i ? DIV_END : DIV_IDLE;
`endif
                DIV_ON: begin
                    if (!bus.start_i)
                        nextState = DIV_IDLE;
                    else if (cnt == DIV_CNT_W'(DIV_ITER - 1))
                        nextState = DIV_END;
                end
                default: nextState = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            resultReg <= '0;
        end else begin
            state <= nextState;
            if (state == DIV_IDLE)
                cnt <= '0;
            else if (state == DIV_ON)
                cnt <= cnt + 1'b1;
            if (ready)
                resultReg <= fixed;
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            DIV_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    rem        <= '0;
                    quo        <= magnitude(bus.opdata1_i, bus.signed_i);
                    divisorMag <= magnitude(bus.opdata2_i, bus.signed_i);
                    negRem     <= bus.signed_i && bus.opdata1_i[WIDTH-1];
                    negQuo     <= bus.signed_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                end
            end
            DIV_BYZERO: begin
                rem <= '0;
                quo <= '0;
            end
            DIV_ON: begin
                rem <= stepRem;
                quo <= stepQuo;
            end
            default: ;
        endcase
    end

    // The pair is presented in END itself so the stage can release its stall that cycle
    assign fixed        = fixUp(rem, quo, negRem, negQuo);
    assign ready        = (state == DIV_END) && !bus.annul_i;
    assign bus.ready_o  = ready;
    assign bus.result_o = ready ? fixed : resultReg;

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2 with an arithmetic reference model and per-cycle output checking.
module tb_div_radix2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    logic rstPrev = 1'b1;
    int   nTests = 0;
    int   nFail = 0;

`ifdef DIV_ZERO_SHORTCUT_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 33;
`endif

    typedef struct {
        int          cyc;
        logic [63:0] res;
    } exp_t;

    exp_t        expQ[$];
    logic [63:0] heldResult = 64'h0;

    div_radix2_if #(.WIDTH(32)) bus ();

    div_radix2 #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rstPrev <= rst;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor follows the built configuration
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) begin
`ifdef DIV_ZERO_SHORTCUT_EN
            return 64'h0;
`else
            return {a, (sgn && a[31]) ? 32'h1 : 32'hFFFFFFFF};
`endif
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // One check of every output on every cycle
    always @(negedge clk) begin
        bit          expReady;
        logic [63:0] expRes;
        if (rstPrev)
            heldResult = 64'h0;
        expReady = (expQ.size() > 0) && (expQ[0].cyc == cyc);
        expRes   = expReady ? expQ[0].res : heldResult;
        chk("ready_o", 64'(bus.ready_o), 64'(expReady));
        chk("result_o", bus.result_o, expRes);
        if (expReady) begin
            heldResult = expQ[0].res;
            void'(expQ.pop_front());
        end
    end

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    // Starts an op in the current cycle and returns inside its ready cycle, start still high
    task automatic startOp(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] lit, input int lat);
        bus.signed_i  = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.start_i   = 1'b1;
        expQ.push_back('{cyc + lat, model(sgn, a, b)});
        nextCyc();
        bus.signed_i  = ~sgn;
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        repeat (lat - 1) nextCyc();
        chk(name, bus.result_o, lit);
    endtask

    task automatic runOp(input string name, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] lit, input int lat);
        startOp(name, sgn, a, b, lit, lat);
        bus.start_i = 1'b0;
        nextCyc();
    endtask

    task automatic annulOp(input logic [31:0] a, input logic [31:0] b, input int annulAt);
        bus.signed_i  = 1'b0;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.start_i   = 1'b1;
        repeat (annulAt) nextCyc();
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        nextCyc();
        bus.annul_i = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'h0;
        bus.opdata2_i = 32'h0;
        bus.start_i   = 1'b0;
        bus.annul_i   = 1'b0;
        repeat (3) nextCyc();
        chk("reset_ready", 64'(bus.ready_o), 64'h0);
        chk("reset_result", bus.result_o, 64'h0);
        rst = 1'b0;
        nextCyc();

        runOp("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        runOp("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
        runOp("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
        runOp("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33);
        runOp("divu_big", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33);
`ifdef DIV_ZERO_SHORTCUT_EN
        runOp("divu_zero", 1'b0, 32'd1234, 32'd0, 64'h0, ZLAT);
        runOp("div_m1234_zero", 1'b1, 32'hFFFFFB2E, 32'd0, 64'h0, ZLAT);
`else
        runOp("divu_zero", 1'b0, 32'd1234, 32'd0, {32'd1234, 32'hFFFFFFFF}, ZLAT);
        runOp("div_m1234_zero", 1'b1, 32'hFFFFFB2E, 32'd0, {32'hFFFFFB2E, 32'h1}, ZLAT);
`endif

        // Flush mid-iteration, then a fresh op straight from the IDLE cycle that follows
        annulOp(32'd50, 32'd5, 10);
        runOp("after_annul", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33);

        // Flush in the END cycle: no ready, previous result held
        annulOp(32'd100, 32'd7, 33);
        chk("annul_end_hold", bus.result_o, {32'd1, 32'd2});
        nextCyc();

        // Back-to-back with start held through END
        startOp("b2b_first", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);
        bus.opdata1_i = 32'd20;
        bus.opdata2_i = 32'd3;
        bus.signed_i  = 1'b0;
        nextCyc();
        runOp("b2b_second", 1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, 33);

        // Reset together with annul while iterating clears result and state
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        repeat (5) nextCyc();
        rst         = 1'b1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        nextCyc();
        rst         = 1'b0;
        bus.annul_i = 1'b0;
        chk("rst_mid_result", bus.result_o, 64'h0);
        runOp("after_rst", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33);

        repeat (5) nextCyc();
        chk("queue_empty", 64'(expQ.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
